// File: rtl/ram_scrambler.sv
// ram_scrambler: scrambled main-RAM port that sits downstream of the tk1 control core.
//
// Logical word addresses are XOR-scrambled with the tk1 address key. Stored data is XOR-masked
// with the tk1 data key and the logical address. Every access takes one accept cycle in IDLE and
// one response cycle in RESP, so the port sustains at most one access every two cycles.
//
// Optional feature (macro RAM_SCRAMBLER_WIPE_EN):
//   defined   - after every reset the whole array is overwritten with WIPE_DATA, one word per
//               cycle, before any request is accepted. wipe_done rises when the sweep completes.
//   undefined - no sweep logic. Reset enters IDLE directly and wipe_done is tied high.
//
// Parameters:
//   ADDR_WIDTH    - word-address width. The array holds 2**ADDR_WIDTH 32-bit words (max 15).
//   WIPE_DATA     - raw physical word written to every location during the sweep.
//
// Ports:
//   clk           - system clock.
//   reset         - synchronous, active-high reset.
//   ram_addr_rand - address scrambling key. Only the low ADDR_WIDTH bits are used.
//   ram_data_rand - data scrambling key.
//   cs            - access request. The requester holds it high until ready.
//   we            - 1 = write, 0 = read. Stable while cs is high.
//   wstrb         - write byte enables. Bit i enables byte i.
//   address       - logical word address.
//   write_data    - write data.
//   read_data     - read data. Valid only in the ready cycle, otherwise 0.
//   ready         - one-cycle completion pulse.
//   wipe_done     - high once the zeroization sweep has finished.

module ram_scrambler #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter logic [31:0] WIPE_DATA  = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [14:0]           ram_addr_rand,
    input  logic [31:0]           ram_data_rand,
    input  logic                  cs,
    input  logic                  we,
    input  logic [3:0]            wstrb,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data,
    output logic                  ready,
    output logic                  wipe_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] StWipe = 2'd0;
    localparam logic [1:0] StIdle = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

`ifdef RAM_SCRAMBLER_WIPE_EN
    localparam logic [1:0]            StReset  = StWipe;
    localparam logic [ADDR_WIDTH-1:0] WipeLast = '1;
`else
    localparam logic [1:0]            StReset  = StIdle;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;   // logical address captured at acceptance
    logic                  we_q, we_d;       // direction captured at acceptance

`ifdef RAM_SCRAMBLER_WIPE_EN
    logic [ADDR_WIDTH-1:0] wipe_ctr_q, wipe_ctr_d;
    logic                  wipe_done_q, wipe_done_d;
`endif

    // ------------------------------------------------------------------
    // Storage and its single write / read port
    // ------------------------------------------------------------------
    logic [31:0]           mem [DEPTH];
    logic [31:0]           mem_rdata_q;      // synchronous read port register
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [31:0]           mem_wdata;
    logic                  mem_re;

    // ------------------------------------------------------------------
    // Scrambling
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] phys_addr;
    logic [31:0]           req_mask;
    logic [31:0]           resp_mask;

    assign phys_addr = address ^ ram_addr_rand[ADDR_WIDTH-1:0];
    assign req_mask  = ram_data_rand ^ {{(32 - ADDR_WIDTH){1'b0}}, address};
    // The response mask uses the captured address so a requester may change the address bus
    // as soon as the request is accepted.
    assign resp_mask = ram_data_rand ^ {{(32 - ADDR_WIDTH){1'b0}}, addr_q};

    // Key bits above ADDR_WIDTH are intentionally ignored for narrower arrays.
    logic unused_addr_key;
    assign unused_addr_key = ^ram_addr_rand;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_waddr = phys_addr;
        mem_wdata = write_data ^ req_mask;
        mem_re    = 1'b0;
`ifdef RAM_SCRAMBLER_WIPE_EN
        wipe_ctr_d  = wipe_ctr_q;
        wipe_done_d = wipe_done_q;
`endif

        case (state_q)
`ifdef RAM_SCRAMBLER_WIPE_EN
            StWipe: begin
                // Raw, unscrambled full-word write. cs is ignored until the sweep ends.
                mem_we     = 1'b1;
                mem_be     = 4'b1111;
                mem_waddr  = wipe_ctr_q;
                mem_wdata  = WIPE_DATA;
                wipe_ctr_d = wipe_ctr_q + 1'b1;
                if (wipe_ctr_q == WipeLast) begin
                    state_d     = StIdle;
                    wipe_done_d = 1'b1;
                end
            end
`endif
            StIdle: begin
                if (cs) begin
                    state_d = StResp;
                    addr_d  = address;
                    we_d    = we;
                    if (we) begin
                        mem_we = 1'b1;
                        mem_be = wstrb;
                    end else begin
                        mem_re = 1'b1;
                    end
                end
            end
            StResp: begin
                // A cs still high here belongs to the request being completed.
                state_d = StIdle;
            end
            default: begin
                state_d = StReset;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StReset;
            addr_q  <= '0;
            we_q    <= 1'b0;
`ifdef RAM_SCRAMBLER_WIPE_EN
            wipe_ctr_q  <= '0;
            wipe_done_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
`ifdef RAM_SCRAMBLER_WIPE_EN
            wipe_ctr_q  <= wipe_ctr_d;
            wipe_done_q <= wipe_done_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Array: byte-enabled write port plus registered read port, no reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && mem_be[i]) begin
                mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
        if (mem_re) begin
            mem_rdata_q <= mem[phys_addr];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ready     = (state_q == StResp);
    assign read_data = (ready && !we_q) ? (mem_rdata_q ^ resp_mask) : 32'h0;

`ifdef RAM_SCRAMBLER_WIPE_EN
    assign wipe_done = wipe_done_q;
`else
    assign wipe_done = 1'b1;
`endif

endmodule

// File: tb/tb_ram_scrambler.sv
// Self-checking bench for ram_scrambler (ADDR_WIDTH = 6). Stimulus pushes the expected
// read_data of every access into a queue; a monitor pops and compares on each ready pulse.
// Wipe-specific sequences run only when RAM_SCRAMBLER_WIPE_EN is defined.

module tb_ram_scrambler;

    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 1 << AW;

`ifdef RAM_SCRAMBLER_WIPE_EN
    localparam logic EXP_WD_RESET = 1'b0;
`else
    localparam logic EXP_WD_RESET = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [14:0]   ram_addr_rand;
    logic [31:0]   ram_data_rand;
    logic          cs;
    logic          we;
    logic [3:0]    wstrb;
    logic [AW-1:0] address;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic          wipe_done;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ram_scrambler #(
        .ADDR_WIDTH (AW),
        .WIPE_DATA  (32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ram_addr_rand (ram_addr_rand),
        .ram_data_rand (ram_data_rand),
        .cs            (cs),
        .we            (we),
        .wstrb         (wstrb),
        .address       (address),
        .write_data    (write_data),
        .read_data     (read_data),
        .ready         (ready),
        .wipe_done     (wipe_done)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares every ready pulse against the scoreboard, and read_data against 0 otherwise.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready with empty scoreboard, read_data %08h",
                         read_data);
            end else begin
                e = exp_q.pop_front();
                check32("read_data", read_data, e);
            end
        end else begin
            check32("idle_read_data_zero", read_data, 32'h0);
        end
    end

    // Issue one access starting #1 after a posedge in IDLE; returns #1 after the edge that
    // brings the FSM back to IDLE.
    task automatic access(input string name, input logic w, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp);
        int n;
        we         = w;
        address    = a;
        write_data = d;
        wstrb      = s;
        cs         = 1'b1;
        exp_q.push_back(exp);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ready !== 1'b1 && n < 20);
        check_int({"latency_", name}, n, 1);
        cs = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] pattern;
        int         n;
        int         bad;
        logic       early;

        reset         = 1'b1;
        cs            = 1'b0;
        we            = 1'b0;
        wstrb         = 4'h0;
        address       = '0;
        write_data    = 32'h0;
        ram_addr_rand = 15'h0005;
        ram_data_rand = 32'hA5A5_5A5A;

        repeat (3) @(posedge clk);
        #1;
        check32("reset_ready", {31'h0, ready}, 32'h0);
        check32("reset_read_data", read_data, 32'h0);
        check32("reset_wipe_done", {31'h0, wipe_done}, {31'h0, EXP_WD_RESET});
        reset = 1'b0;

`ifdef RAM_SCRAMBLER_WIPE_EN
        // Hold a read of address 0 through the whole sweep.
        we      = 1'b0;
        address = '0;
        cs      = 1'b1;
        exp_q.push_back(32'hA5A5_5A5A);
        n     = 0;
        early = 1'b0;
        while (wipe_done !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (ready === 1'b1) early = 1'b1;
        end
        check_int("wipe_cycles", n, 64);
        check_int("no_ready_during_wipe", int'(early), 0);
        @(posedge clk);
        #1;
        check_int("wipe_read_ready", int'(ready), 1);
        cs = 1'b0;
        @(posedge clk);
        #1;
`endif

        // Round trip; without the wipe this is also the first access right after reset.
        access("wr_round_trip", 1'b1, 6'h03, 32'hDEAD_BEEF, 4'hF, 32'h0);
        check32("phys_word_6", dut.mem[6], 32'h7B08_E4B6);
        access("rd_round_trip", 1'b0, 6'h03, 32'h0, 4'h0, 32'hDEAD_BEEF);

        // Byte strobes, then a no-strobe write that must leave the word untouched.
        access("wr_full", 1'b1, 6'h09, 32'h1122_3344, 4'hF, 32'h0);
        access("wr_strb", 1'b1, 6'h09, 32'hFFFF_FFFF, 4'b0101, 32'h0);
        access("rd_strb", 1'b0, 6'h09, 32'h0, 4'h0, 32'h11FF_33FF);
        access("wr_nostrb", 1'b1, 6'h09, 32'h0, 4'h0, 32'h0);
        access("rd_nostrb", 1'b0, 6'h09, 32'h0, 4'h0, 32'h11FF_33FF);

        // Back-to-back reads with cs held high: ready on alternating cycles.
        we      = 1'b0;
        address = 6'h03;
        cs      = 1'b1;
        repeat (3) exp_q.push_back(32'hDEAD_BEEF);
        pattern    = '0;
        pattern[0] = ready;
        for (int i = 1; i < 6; i++) begin
            @(posedge clk);
            #1;
            pattern[i] = ready;
        end
        cs = 1'b0;
        check32("b2b_ready_pattern", {26'h0, pattern}, {26'h0, 6'b101010});
        @(posedge clk);
        #1;

        // All-ones address with all-ones key lands on physical word 0.
        ram_addr_rand = 15'h7FFF;
        access("wr_ones", 1'b1, 6'h3F, 32'h1234_5678, 4'hF, 32'h0);
        check32("phys_word_0", dut.mem[0], 32'hB791_0C1D);
        access("rd_ones", 1'b0, 6'h3F, 32'h0, 4'h0, 32'h1234_5678);
        ram_addr_rand = 15'h0005;

        // Key change: old data reads back masked by the old data key only.
        ram_data_rand = 32'h0;
        access("rd_key_change", 1'b0, 6'h03, 32'h0, 4'h0, 32'h7B08_E4B5);

`ifdef RAM_SCRAMBLER_WIPE_EN
        // Reset 30 cycles into a sweep; the sweep must restart and clear every word.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_int("midwipe_reset_wipe_done", int'(wipe_done), 0);
        reset = 1'b0;
        n = 0;
        while (wipe_done !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_int("rewipe_cycles", n, 64);
        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (dut.mem[i] !== 32'h0) bad++;
        end
        check_int("rewipe_words_nonzero", bad, 0);
        access("rd_after_rewipe", 1'b0, 6'h03, 32'h0, 4'h0, 32'h0000_0003);
`endif

        repeat (3) @(posedge clk);
        #1;
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
